// File: rtl/l2_tagdata_array_plru_pkg.sv
// Shared meta encoding, FSM states and sizing helper for the L2 tag/data array.
package l2_pkg;

  localparam int unsigned META_W = 3;
  localparam int unsigned PERM_W = 2;

  localparam logic [PERM_W-1:0] PERM_N = 2'd0;
  localparam logic [PERM_W-1:0] PERM_B = 2'd1;
  localparam logic [PERM_W-1:0] PERM_T = 2'd2;

  // Bit 2 is the dirty flag; perm 3 is reserved and behaves like T.
  typedef struct packed {
    logic              dirty;
    logic [PERM_W-1:0] perm;
  } meta_t;

  typedef enum logic {
    ST_SWEEP = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((64'd1 << res) < 64'(value)) res++;
    return res;
  endfunction

endpackage

// File: rtl/l2_tagdata_array_plru_if.sv
// Lookup, fill and response bundle between the coherence controller and the L2 array.
interface l2_tagdata_array_plru_if
  import l2_pkg::*;
#(
  parameter int unsigned WAYS   = 16,
  parameter int unsigned SETS   = 256,
  parameter int unsigned WORDS  = 8,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned TAG_W  = 50
) ();

  localparam int unsigned IDX_W  = clog2(SETS);
  localparam int unsigned WOFF_W = clog2(WORDS);
  localparam int unsigned WAY_W  = clog2(WAYS);
  localparam int unsigned BE_W   = DATA_W / 8;

  logic              ready_o;
  logic              inv_all_i;
  logic              lk_valid_i;
  logic [IDX_W-1:0]  lk_index_i;
  logic [WOFF_W-1:0] lk_word_i;
  logic [TAG_W-1:0]  lk_tag_i;
  logic              rsp_valid_o;
  logic              rsp_hit_o;
  logic [WAY_W-1:0]  rsp_hit_way_o;
  logic [META_W-1:0] rsp_meta_o;
  logic [DATA_W-1:0] rsp_rdata_o;
  logic [WAY_W-1:0]  rsp_victim_way_o;
  logic [TAG_W-1:0]  rsp_victim_tag_o;
  logic [META_W-1:0] rsp_victim_meta_o;
  logic              wr_data_we_i;
  logic              wr_tag_we_i;
  logic [IDX_W-1:0]  wr_index_i;
  logic [WOFF_W-1:0] wr_word_i;
  logic [WAY_W-1:0]  wr_way_i;
  logic [BE_W-1:0]   wr_be_i;
  logic [DATA_W-1:0] wr_wdata_i;
  logic [TAG_W-1:0]  wr_tag_i;
  logic [META_W-1:0] wr_meta_i;

  modport master (
    input  ready_o, rsp_valid_o, rsp_hit_o, rsp_hit_way_o, rsp_meta_o, rsp_rdata_o,
           rsp_victim_way_o, rsp_victim_tag_o, rsp_victim_meta_o,
    output inv_all_i, lk_valid_i, lk_index_i, lk_word_i, lk_tag_i,
           wr_data_we_i, wr_tag_we_i, wr_index_i, wr_word_i, wr_way_i, wr_be_i,
           wr_wdata_i, wr_tag_i, wr_meta_i
  );

  modport slave (
    output ready_o, rsp_valid_o, rsp_hit_o, rsp_hit_way_o, rsp_meta_o, rsp_rdata_o,
           rsp_victim_way_o, rsp_victim_tag_o, rsp_victim_meta_o,
    input  inv_all_i, lk_valid_i, lk_index_i, lk_word_i, lk_tag_i,
           wr_data_we_i, wr_tag_we_i, wr_index_i, wr_word_i, wr_way_i, wr_be_i,
           wr_wdata_i, wr_tag_i, wr_meta_i
  );

endinterface

// File: rtl/l2_tagdata_array_plru_tree.sv
// Tree pseudo-LRU for one set: victim walk plus the node updates for touching a way.
module l2_plru_tree
  import l2_pkg::*;
#(
  parameter  int unsigned WAYS  = 16,
  localparam int unsigned WAY_W = clog2(WAYS)
) (
  input  logic [WAYS-2:0]  tree,
  input  logic [WAY_W-1:0] touch_way,
  output logic [WAY_W-1:0] victim,
  output logic [WAYS-2:0]  next_tree,
  output logic [WAYS-2:0]  touch_mask
);

  logic [WAY_W:0]   vnode;
  logic [WAY_W-1:0] tnode;
  logic [WAY_W-1:0] tw;

  // Heap-ordered nodes; a node bit of 1 sends the victim walk to the right child.
  always_comb begin
    vnode = '0;
    for (int lvl = 0; lvl < int'(WAY_W); lvl++) begin
      vnode = {vnode[WAY_W-1:0], 1'b1} + (WAY_W+1)'(tree[vnode[WAY_W-1:0]]);
    end
    victim = WAY_W'(vnode - (WAY_W+1)'(WAYS - 1));
  end

  // The mask marks the path nodes so callers can apply the touch to a newer tree.
  always_comb begin
    next_tree  = tree;
    touch_mask = '0;
    tnode      = '0;
    tw         = touch_way;
    for (int lvl = 0; lvl < int'(WAY_W); lvl++) begin
      next_tree[tnode]  = ~tw[WAY_W-1];
      touch_mask[tnode] = 1'b1;
      tnode             = WAY_W'({tnode, 1'b1} + (WAY_W+1)'(tw[WAY_W-1]));
      tw                = tw << 1;
    end
  end

endmodule

// File: rtl/l2_tagdata_array_plru.sv
// L2 tag/data/meta store: one-cycle registered lookup, tree PLRU victim, set-sweep invalidate.
module l2_tagdata_array_plru
  import l2_pkg::*;
#(
  parameter int unsigned WAYS   = 16,
  parameter int unsigned SETS   = 256,
  parameter int unsigned WORDS  = 8,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned TAG_W  = 50
) (
  input logic                     clk_i,
  input logic                     rst_i,
  l2_tagdata_array_plru_if.slave  bus
);

  localparam int unsigned IDX_W  = clog2(SETS);
  localparam int unsigned WOFF_W = clog2(WORDS);
  localparam int unsigned WAY_W  = clog2(WAYS);
  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned TREE_W = WAYS - 1;
  localparam int unsigned ADDR_W = IDX_W + WAY_W + WOFF_W;
  localparam int unsigned DEPTH  = SETS * WAYS * WORDS;

  logic [WAYS-1:0][TAG_W-1:0] tag_mem  [SETS];
  meta_t [WAYS-1:0]           meta_mem [SETS];
  logic [TREE_W-1:0]          plru_mem [SETS];
  logic [DATA_W-1:0]          data_mem [DEPTH];

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             ready_q;

  logic accept_c, lk_fire_c, wr_data_fire_c, wr_tag_fire_c;

  assign accept_c       = (state_q == ST_IDLE) && !bus.inv_all_i && !rst_i;
  assign lk_fire_c      = accept_c && bus.lk_valid_i;
  assign wr_data_fire_c = accept_c && bus.wr_data_we_i;
  assign wr_tag_fire_c  = accept_c && bus.wr_tag_we_i;
  assign bus.ready_o    = ready_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_SWEEP;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == ST_IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_SWEEP: begin
        cnt_d = cnt_q + IDX_W'(1);
        if (cnt_q == IDX_W'(SETS - 1)) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (bus.inv_all_i) begin
          state_d = ST_SWEEP;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_SWEEP;
    endcase
  end

  // Lookup side: tag compare across the addressed set, lowest matching or free way wins.
  logic [WAYS-1:0][TAG_W-1:0] tag_row_c;
  meta_t [WAYS-1:0]           meta_row_c;
  logic [TREE_W-1:0]          lk_tree_c, lk_next_c, lk_mask_c;
  logic                       hit_c, free_c;
  logic [WAY_W-1:0]           hit_way_c, free_way_c, plru_victim_c, victim_way_c;
  logic [DATA_W-1:0]          rdata_c;

  assign tag_row_c  = tag_mem[bus.lk_index_i];
  assign meta_row_c = meta_mem[bus.lk_index_i];
  assign lk_tree_c  = plru_mem[bus.lk_index_i];

  always_comb begin
    hit_c      = 1'b0;
    hit_way_c  = '0;
    free_c     = 1'b0;
    free_way_c = '0;
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (meta_row_c[w].perm != PERM_N) begin
        if (tag_row_c[w] == bus.lk_tag_i) begin
          hit_c     = 1'b1;
          hit_way_c = WAY_W'(w);
        end
      end else begin
        free_c     = 1'b1;
        free_way_c = WAY_W'(w);
      end
    end
  end

  assign victim_way_c = free_c ? free_way_c : plru_victim_c;
  assign rdata_c      = hit_c ? data_mem[{bus.lk_index_i, hit_way_c, bus.lk_word_i}] : '0;

  l2_plru_tree #(.WAYS(WAYS)) u_lk_tree (
    .tree       (lk_tree_c),
    .touch_way  (hit_way_c),
    .victim     (plru_victim_c),
    .next_tree  (lk_next_c),
    .touch_mask (lk_mask_c)
  );

  // Write side: tag-write PLRU touch and byte-merged data word.
  logic [TREE_W-1:0]  wr_tree_c, wr_next_c, wr_mask_c;
  logic [WAY_W-1:0]   wr_victim_unused;
  logic [ADDR_W-1:0]  wr_addr_c;
  logic [DATA_W-1:0]  merged_c;

  assign wr_tree_c = plru_mem[bus.wr_index_i];
  assign wr_addr_c = {bus.wr_index_i, bus.wr_way_i, bus.wr_word_i};

  l2_plru_tree #(.WAYS(WAYS)) u_wr_tree (
    .tree       (wr_tree_c),
    .touch_way  (bus.wr_way_i),
    .victim     (wr_victim_unused),
    .next_tree  (wr_next_c),
    .touch_mask (wr_mask_c)
  );

  always_comb begin
    merged_c = data_mem[wr_addr_c];
    for (int b = 0; b < int'(BE_W); b++) begin
      if (bus.wr_be_i[b]) merged_c[b*8 +: 8] = bus.wr_wdata_i[b*8 +: 8];
    end
  end

  // Hit touch is applied one edge later, on top of whatever the set holds then.
  logic              upd_q;
  logic [IDX_W-1:0]  upd_set_q;
  logic [TREE_W-1:0] upd_next_q, upd_mask_q;

  always_ff @(posedge clk_i) begin
    if (state_q == ST_SWEEP) begin
      meta_mem[cnt_q] <= '0;
      plru_mem[cnt_q] <= '0;
    end
    if (upd_q) begin
      plru_mem[upd_set_q] <= (plru_mem[upd_set_q] & ~upd_mask_q) | (upd_next_q & upd_mask_q);
    end
    // Placed after the hit touch so a same-set write touch takes precedence.
    if (wr_tag_fire_c) begin
      tag_mem[bus.wr_index_i][bus.wr_way_i]  <= bus.wr_tag_i;
      meta_mem[bus.wr_index_i][bus.wr_way_i] <= meta_t'(bus.wr_meta_i);
      plru_mem[bus.wr_index_i]               <= (wr_tree_c & ~wr_mask_c) | (wr_next_c & wr_mask_c);
    end
    if (wr_data_fire_c) data_mem[wr_addr_c] <= merged_c;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.rsp_valid_o       <= 1'b0;
      bus.rsp_hit_o         <= 1'b0;
      bus.rsp_hit_way_o     <= '0;
      bus.rsp_meta_o        <= '0;
      bus.rsp_rdata_o       <= '0;
      bus.rsp_victim_way_o  <= '0;
      bus.rsp_victim_tag_o  <= '0;
      bus.rsp_victim_meta_o <= '0;
      upd_q                 <= 1'b0;
      upd_set_q             <= '0;
      upd_next_q            <= '0;
      upd_mask_q            <= '0;
    end else begin
      bus.rsp_valid_o <= lk_fire_c;
      upd_q           <= lk_fire_c && hit_c;
      if (lk_fire_c) begin
        bus.rsp_hit_o         <= hit_c;
        bus.rsp_hit_way_o     <= hit_way_c;
        bus.rsp_meta_o        <= hit_c ? meta_row_c[hit_way_c] : '0;
        bus.rsp_rdata_o       <= rdata_c;
        bus.rsp_victim_way_o  <= victim_way_c;
        bus.rsp_victim_tag_o  <= tag_row_c[victim_way_c];
        bus.rsp_victim_meta_o <= meta_row_c[victim_way_c];
        upd_set_q             <= bus.lk_index_i;
        upd_next_q            <= lk_next_c;
        upd_mask_q            <= lk_mask_c;
      end
    end
  end

endmodule
